// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: the MEM/WB stage state encoding and the default
// payload width of the MEM/WB beat.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ONE    = 2'd1,
        TWO    = 2'd2,
        HALTED = 2'd3
    } pipe_state_t;

    localparam int MEM_WB_W = 136;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// Bundle of every mem_wb_pipe signal, with one view for the stage and one for
// the bench driving it.
interface mem_wb_pipe_if #(
    parameter int WIDTH  = cpu_types_pkg::MEM_WB_W,
    parameter int STAT_W = 32
) (
    input logic CLK,
    input logic nRST
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_halt;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_halt;
    logic              halted;
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] bubble_cnt;

    modport stage (
        input  CLK, nRST, flush, in_valid, in_data, in_halt, out_ready,
        output in_ready, out_valid, out_data, out_halt, halted, stall_cnt, bubble_cnt
    );

    modport bench (
        input  CLK, nRST, in_ready, out_valid, out_data, out_halt, halted, stall_cnt, bubble_cnt,
        output flush, in_valid, in_data, in_halt, out_ready
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB handshaked stage: main slot plus a one-entry skid slot so in_ready is
// registered. Optional performance counters are enabled by defining PIPE_STAT_EN.
module mem_wb_pipe
    import cpu_types_pkg::*;
#(
    parameter int WIDTH  = MEM_WB_W,
    parameter int STAT_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_halt,
    output logic              halted,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] bubble_cnt
);
    pipe_state_t      state_reg, state_next;
    logic [WIDTH-1:0] main_data_reg, main_data_next;
    logic             main_halt_reg, main_halt_next;
    logic             main_valid_reg, main_valid_next;
    logic [WIDTH-1:0] skid_data_reg, skid_data_next;
    logic             skid_halt_reg, skid_halt_next;
    logic             skid_valid_reg, skid_valid_next;
    logic             in_ready_reg, in_ready_next;
    logic             accept;
    logic             retire;

    assign accept = in_valid & in_ready_reg;
    assign retire = main_valid_reg & out_ready;

    always_comb begin
        state_next      = state_reg;
        main_data_next  = main_data_reg;
        main_halt_next  = main_halt_reg;
        main_valid_next = main_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_halt_next  = skid_halt_reg;
        skid_valid_next = skid_valid_reg;

        if (state_reg != HALTED) begin
            // A retiring halt beat wins over flush and over any same-cycle accept.
            if (retire && main_halt_reg) begin
                state_next      = HALTED;
                main_data_next  = '0;
                main_halt_next  = 1'b0;
                main_valid_next = 1'b0;
                skid_data_next  = '0;
                skid_halt_next  = 1'b0;
                skid_valid_next = 1'b0;
            end else if (flush) begin
                state_next      = EMPTY;
                main_data_next  = '0;
                main_halt_next  = 1'b0;
                main_valid_next = 1'b0;
                skid_data_next  = '0;
                skid_halt_next  = 1'b0;
                skid_valid_next = 1'b0;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (accept) begin
                            state_next      = ONE;
                            main_data_next  = in_data;
                            main_halt_next  = in_halt;
                            main_valid_next = 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && retire) begin
                            main_data_next = in_data;
                            main_halt_next = in_halt;
                        end else if (accept) begin
                            state_next      = TWO;
                            skid_data_next  = in_data;
                            skid_halt_next  = in_halt;
                            skid_valid_next = 1'b1;
                        end else if (retire) begin
                            state_next      = EMPTY;
                            main_data_next  = '0;
                            main_halt_next  = 1'b0;
                            main_valid_next = 1'b0;
                        end
                    end
                    TWO: begin
                        if (retire) begin
                            state_next      = ONE;
                            main_data_next  = skid_data_reg;
                            main_halt_next  = skid_halt_reg;
                            skid_data_next  = '0;
                            skid_halt_next  = 1'b0;
                            skid_valid_next = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        in_ready_next = (state_next == EMPTY) || (state_next == ONE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= EMPTY;
            main_data_reg  <= '0;
            main_halt_reg  <= 1'b0;
            main_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_halt_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            main_data_reg  <= main_data_next;
            main_halt_reg  <= main_halt_next;
            main_valid_reg <= main_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_halt_reg  <= skid_halt_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign out_halt  = main_halt_reg;
    assign halted    = (state_reg == HALTED);

`ifdef PIPE_STAT_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = main_valid_reg & ~out_ready;
    assign bubble_inc = ~main_valid_reg & (state_reg != HALTED);

    sat_counter #(.W(STAT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (stall_inc),
        .cnt  (stall_cnt)
    );

    sat_counter #(.W(STAT_W)) u_bubble_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (bubble_inc),
        .cnt  (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
